// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory port between instruction fetch (I) and
// load/store (D). Round-robin tie-break, req/ack handshake toward both
// requesters, and a per-transaction timeout that aborts with err.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   // fetch requester
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   // load/store requester
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              err,
   // memory side
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                i_ack_q, i_ack_d;
   logic                d_ack_q, d_ack_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                last_d_q, last_d_d;   // 1: last grant went to D
   logic                gnt_d_q, gnt_d_d;     // 1: current transaction belongs to D
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                sel_d;                // D wins arbitration this cycle

   // Next-state and registered-output logic for the arbitration FSM
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      err_d       = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      last_d_d    = last_d_q;
      gnt_d_d     = gnt_d_q;
      cnt_d       = cnt_q;
      // On a tie, the requester that was not served last goes first
      sel_d       = d_req && (!i_req || !last_d_q);

      unique case (state_q)
         StIdle: begin
            if (i_req || d_req) begin
               gnt_d_d    = sel_d;
               last_d_d   = sel_d;
               mem_req_d  = 1'b1;
               mem_addr_d = sel_d ? d_addr : i_addr;
               mem_we_d   = sel_d && d_we;
               if (sel_d) begin
                  mem_wdata_d = d_wdata;
               end
               cnt_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            // A completion arriving on the final wait cycle still counts as success
            if (mem_ack) begin
               mem_req_d = 1'b0;
               if (gnt_d_q) begin
                  d_ack_d = 1'b1;
                  if (!mem_we_q) begin
                     d_rdata_d = mem_rdata;
                  end
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = mem_rdata;
               end
               state_d = StResp;
            end else if (cnt_q == CntLast) begin
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               if (gnt_d_q) begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = '0;
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = '0;
               end
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StResp: begin
            // ack is visible this cycle; requests are deliberately not sampled
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         err_q       <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         last_d_q    <= 1'b0;
         gnt_d_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         err_q       <= err_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         last_d_q    <= last_d_d;
         gnt_d_q     <= gnt_d_d;
         cnt_q       <= cnt_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign err       = err_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a timeline model.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, d_req, d_we, mem_ack;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic          i_ack, d_ack, err, mem_req, mem_we;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   typedef struct {
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        mack;
      logic [31:0] mrdata;
      logic        e_mreq;
      logic        e_mwe;
      logic [31:0] e_maddr;
      logic [31:0] e_mwdata;
      logic        e_iack;
      logic        e_dack;
      logic        e_err;
      logic [31:0] e_ird;
      logic [31:0] e_drd;
   } vec_t;

   vec_t vecs[10];

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
   endtask

   // Fields of one vector-table row
   function automatic vec_t mk(input logic rst, input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe, input logic [31:0] daddr,
                               input logic [31:0] dwdata, input logic mack,
                               input logic [31:0] mrdata, input logic e_mreq,
                               input logic e_mwe, input logic [31:0] e_maddr,
                               input logic [31:0] e_mwdata, input logic e_iack,
                               input logic e_dack, input logic e_err,
                               input logic [31:0] e_ird, input logic [31:0] e_drd);
      vec_t v;
      v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
      v.daddr = daddr; v.dwdata = dwdata; v.mack = mack; v.mrdata = mrdata;
      v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
      v.e_iack = e_iack; v.e_dack = e_dack; v.e_err = e_err; v.e_ird = e_ird;
      v.e_drd = e_drd;
      return v;
   endfunction

   // Timeline reference model state for the random phase
   int            t, g, k, w, idle_from;
   bit            busy, who_d, m_err, last_d;
   logic [31:0]   m_data, e_ird, e_drd, g_addr, g_wdata;
   bit            g_we;
   bit            ip, dp, dwe_r;
   logic [31:0]   ia, da, dwd;
   bit            e_mreq, e_iack, e_dack, e_err;

   initial begin
      // reset, stray mem_ack, fetch with one wait cycle, zero-wait store
      vecs[0] = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      vecs[1] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF,
                   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      vecs[2] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      vecs[3] = mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      vecs[4] = mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      vecs[5] = mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h00500093,
                   1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h0);
      vecs[6] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h0);
      vecs[7] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0,
                   1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h0);
      vecs[8] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b1, 32'h12345678,
                   1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h00500093, 32'h0);
      vecs[9] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h0);

      reset = 1'b1;
      idle_inputs();

      for (int i = 0; i < 10; i++) begin
         reset = vecs[i].rst; i_req = vecs[i].ireq; i_addr = vecs[i].iaddr;
         d_req = vecs[i].dreq; d_we = vecs[i].dwe; d_addr = vecs[i].daddr;
         d_wdata = vecs[i].dwdata; mem_ack = vecs[i].mack; mem_rdata = vecs[i].mrdata;
         step();
         chk1($sformatf("v%0d mem_req", i), mem_req, vecs[i].e_mreq);
         chk1($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_mwe);
         chk32($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
         chk32($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
         chk1($sformatf("v%0d i_ack", i), i_ack, vecs[i].e_iack);
         chk1($sformatf("v%0d d_ack", i), d_ack, vecs[i].e_dack);
         chk1($sformatf("v%0d err", i), err, vecs[i].e_err);
         chk32($sformatf("v%0d i_rdata", i), i_rdata, vecs[i].e_ird);
         chk32($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_drd);
      end

      // Ties from reset: D, then I, then D again
      reset = 1'b1; idle_inputs(); step(); reset = 1'b0;
      i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
      step(); chk1("tie1 mem_req", mem_req, 1'b1); chk32("tie1 addr", mem_addr, 32'h300);
      step(); chk1("tie1 d_ack", d_ack, 1'b1); chk1("tie1 i_ack", i_ack, 1'b0);
      chk32("tie1 d_rdata", d_rdata, 32'hA5A5A5A5);
      d_addr = 32'h304;
      step(); chk1("tie1 resp mem_req", mem_req, 1'b0); chk1("tie1 d_ack end", d_ack, 1'b0);
      step(); chk1("tie2 mem_req", mem_req, 1'b1); chk32("tie2 addr", mem_addr, 32'h40);
      chk1("tie2 mem_we", mem_we, 1'b0);
      step(); chk1("tie2 i_ack", i_ack, 1'b1); chk32("tie2 i_rdata", i_rdata, 32'hA5A5A5A5);
      i_addr = 32'h44;
      step(); chk1("tie2 resp mem_req", mem_req, 1'b0);
      step(); chk32("tie3 addr", mem_addr, 32'h304);
      step(); chk1("tie3 d_ack", d_ack, 1'b1);
      i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
      step(); chk1("tie3 i_ack", i_ack, 1'b0);

      // Timeout: memory never answers
      i_req = 1'b1; i_addr = 32'h80;
      for (int c = 0; c < int'(TO); c++) begin
         step(); chk1($sformatf("to mem_req c%0d", c), mem_req, 1'b1);
      end
      step(); chk1("to mem_req off", mem_req, 1'b0); chk1("to i_ack", i_ack, 1'b1);
      chk1("to err", err, 1'b1); chk32("to i_rdata", i_rdata, 32'h0);
      chk1("to d_ack", d_ack, 1'b0);
      i_req = 1'b0;
      step(); chk1("to i_ack end", i_ack, 1'b0); chk1("to err end", err, 1'b0);
      step(); chk1("to idle", mem_req, 1'b0);

      // Reset in the second ISSUE cycle, then a fresh load
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      step(); chk1("rst grant", mem_req, 1'b1);
      step(); chk1("rst issue", mem_req, 1'b1);
      reset = 1'b1;
      step(); chk1("rst mem_req", mem_req, 1'b0); chk1("rst d_ack", d_ack, 1'b0);
      chk1("rst err", err, 1'b0); chk32("rst mem_addr", mem_addr, 32'h0);
      reset = 1'b0; d_addr = 32'h504; mem_ack = 1'b1; mem_rdata = 32'h77;
      step(); chk1("rst2 mem_req", mem_req, 1'b1); chk32("rst2 addr", mem_addr, 32'h504);
      step(); chk1("rst2 d_ack", d_ack, 1'b1); chk32("rst2 d_rdata", d_rdata, 32'h77);
      chk1("rst2 err", err, 1'b0);
      d_req = 1'b0; mem_ack = 1'b0;
      step();

      // Randomized traffic against a timeline model
      reset = 1'b1; idle_inputs(); step(); reset = 1'b0;
      busy = 1'b0; idle_from = 0; last_d = 1'b0; e_ird = '0; e_drd = '0;
      ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dwd = '0; dwe_r = 1'b0;
      g = 0; k = 0; w = 0; who_d = 1'b0; m_err = 1'b0; m_data = '0;
      g_addr = '0; g_wdata = '0; g_we = 1'b0;
      for (t = 0; t < 3000; t++) begin
         e_mreq = busy && t >= g && t <= g + k - 1;
         e_iack = busy && t == g + k && !who_d;
         e_dack = busy && t == g + k && who_d;
         e_err  = busy && t == g + k && m_err;
         if (busy && t == g + k) begin
            if (m_err) begin
               if (who_d) e_drd = '0; else e_ird = '0;
            end else if (!who_d) begin
               e_ird = m_data;
            end else if (!g_we) begin
               e_drd = m_data;
            end
         end
         chk1($sformatf("r%0d mem_req", t), mem_req, e_mreq);
         if (e_mreq) begin
            chk32($sformatf("r%0d mem_addr", t), mem_addr, g_addr);
            chk1($sformatf("r%0d mem_we", t), mem_we, g_we);
            if (g_we) chk32($sformatf("r%0d mem_wdata", t), mem_wdata, g_wdata);
         end
         chk1($sformatf("r%0d i_ack", t), i_ack, e_iack);
         chk1($sformatf("r%0d d_ack", t), d_ack, e_dack);
         chk1($sformatf("r%0d err", t), err, e_err);
         chk32($sformatf("r%0d i_rdata", t), i_rdata, e_ird);
         chk32($sformatf("r%0d d_rdata", t), d_rdata, e_drd);

         if (busy && t == g + k) begin
            if (who_d) dp = 1'b0; else ip = 1'b0;
            busy = 1'b0;
         end
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1'b1; ia = $urandom;
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1'b1; da = $urandom; dwd = $urandom; dwe_r = 1'($urandom_range(0, 1));
         end
         i_req = ip; i_addr = ia; d_req = dp; d_addr = da; d_wdata = dwd; d_we = dwe_r;

         if (!busy && t >= idle_from && (ip || dp)) begin
            who_d = dp && (!ip || !last_d);
            last_d = who_d;
            g = t + 1;
            w = int'($urandom_range(0, TO + 1));
            m_err = w >= int'(TO);
            k = m_err ? int'(TO) : w + 1;
            m_data = $urandom;
            busy = 1'b1;
            idle_from = g + k + 1;
            g_addr = who_d ? da : ia;
            g_we = who_d && dwe_r;
            g_wdata = dwd;
         end

         if (busy && t >= g && t <= g + k - 1) begin
            mem_ack = (t == g + w);
            mem_rdata = (t == g + w) ? m_data : $urandom;
         end else begin
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
